// File: rtl/xc_aesmix_seq.sv
// Request-side sequencer for a shared xc_aesmix unit: splits a 128-bit AES state
// into four single-column MixColumns operations and reassembles the response.
module xc_aesmix_seq #(
  parameter int MAX_WAIT = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_state,
  input  logic         req_enc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         rsp_error,
  output logic         mix_valid,
  output logic [31:0]  mix_rs1,
  output logic [31:0]  mix_rs2,
  output logic [31:0]  mix_enc,
  input  logic         mix_ready,
  input  logic [31:0]  mix_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t       state_q;
  state_t       state_d;

  logic [127:0] src_p0;
  logic [1:0]   col_p0;
  logic [7:0]   wait_cnt;

  logic [31:0]  rs1_p1;
  logic [31:0]  rs2_p1;
  logic         enc_p1;
  logic [127:0] res_p1;
  logic         err_p1;

  logic         accept;
  logic         capture;
  logic         stall;
  logic         timeout;
  logic         last_col;
  logic [1:0]   col_nx;
  logic [7:0]   wait_nx;

  // The unit expects the low byte pair in rs1[15:0] and the high pair in rs2[31:16].
  function automatic logic [31:0] pack_rs1(input logic [31:0] c);
    return {16'h0000, c[15:0]};
  endfunction

  function automatic logic [31:0] pack_rs2(input logic [31:0] c);
    return {c[31:16], 16'h0000};
  endfunction

  assign accept   = (state_q == IDLE) && req_valid;
  assign capture  = (state_q == RUN) && mix_ready;
  assign stall    = (state_q == RUN) && !mix_ready;
  assign last_col = (col_p0 == 2'd3);
  assign col_nx   = col_p0 + 2'd1;
  assign wait_nx  = wait_cnt + 8'd1;
  assign timeout  = stall && (wait_nx == WAIT_LIM);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if ((capture && last_col) || timeout) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mix_valid = (state_q == RUN);
    rsp_valid = (state_q == RESP);
    rsp_state = res_p1;
    rsp_error = err_p1;
    mix_rs1   = rs1_p1;
    mix_rs2   = rs2_p1;
    mix_enc   = {31'b0, enc_p1};
  end

  // Stage p0: latched request state, column pointer and per-column stall counter.
  // Stage p1: operands presented to the unit and the collected result columns.
  always_ff @(posedge clock) begin
    if (!reset) begin
      src_p0   <= '0;
      col_p0   <= 2'd0;
      wait_cnt <= 8'd0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      enc_p1   <= 1'b0;
      res_p1   <= '0;
      err_p1   <= 1'b0;
    end else begin
      if (accept) begin
        src_p0   <= req_state;
        col_p0   <= 2'd0;
        wait_cnt <= 8'd0;
        err_p1   <= 1'b0;
        rs1_p1   <= pack_rs1(req_state[31:0]);
        rs2_p1   <= pack_rs2(req_state[31:0]);
        enc_p1   <= req_enc;
      end

      if (capture) begin
        res_p1[{col_p0, 5'b0} +: 32] <= mix_result;
        wait_cnt                     <= 8'd0;
        // Operands advance only on a capture edge, so they stay stable while stalled.
        if (!last_col) begin
          col_p0 <= col_nx;
          rs1_p1 <= pack_rs1(src_p0[{col_nx, 5'b0} +: 32]);
          rs2_p1 <= pack_rs2(src_p0[{col_nx, 5'b0} +: 32]);
        end
      end

      if (stall) begin
        wait_cnt <= wait_nx;
        if (timeout) begin
          err_p1 <= 1'b1;
          res_p1 <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xc_aesmix_seq.sv
// Bench for xc_aesmix_seq: a behavioural MixColumns unit with programmable ready
// delay, a protocol-level reference model and directed request scenarios.
module tb_xc_aesmix_seq;

  localparam int MAX_WAIT = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_state;
  logic         req_enc;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_state;
  logic         rsp_error;
  logic         mix_valid;
  logic [31:0]  mix_rs1;
  logic [31:0]  mix_rs2;
  logic [31:0]  mix_enc;
  logic         mix_ready;
  logic [31:0]  mix_result;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int delay    = 0;
  logic stall_all = 1'b0;
  int wcnt = 0;

  xc_aesmix_seq #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state), .req_enc(req_enc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state), .rsp_error(rsp_error),
    .mix_valid(mix_valid), .mix_rs1(mix_rs1), .mix_rs2(mix_rs2), .mix_enc(mix_enc),
    .mix_ready(mix_ready), .mix_result(mix_result)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c, input logic enc);
    logic [3:0] m [4];
    logic [7:0] a [4];
    logic [31:0] r;
    if (enc) begin
      m[0] = 4'd2;  m[1] = 4'd3;  m[2] = 4'd1;  m[3] = 4'd1;
    end else begin
      m[0] = 4'd14; m[1] = 4'd11; m[2] = 4'd13; m[3] = 4'd9;
    end
    for (int i = 0; i < 4; i++) a[i] = c[8*i +: 8];
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[8*i +: 8] = r[8*i +: 8] ^ gm(a[(i + j) % 4], m[j]);
    return r;
  endfunction

  function automatic logic [127:0] mixstate(input logic [127:0] s, input logic enc);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = mixcol(s[32*i +: 32], enc);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural MixColumns unit: result is combinational, ready after `delay` waiting cycles.
  assign mix_ready  = !stall_all && (wcnt >= delay);
  assign mix_result = mixcol({mix_rs2[31:16], mix_rs1[15:0]}, mix_enc[0]);

  always @(posedge clock) begin
    if (!reset || !mix_valid || mix_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Reference model and per-cycle compare; model advances to the value after the next edge.
  initial begin
    logic mv, just_rst, eenc, eerr, pstall;
    int ph, k, nr;
    logic [127:0] est, ersp;
    logic [31:0] prs1, prs2, penc;
    mv = 1'b0; just_rst = 1'b0; eenc = 1'b0; eerr = 1'b0; pstall = 1'b0;
    ph = 0; k = 0; nr = 0; est = '0; ersp = '0; prs1 = '0; prs2 = '0; penc = '0;
    forever begin
      @(negedge clock);
      if (mv) begin
        chk("req_ready", 128'(req_ready), 128'(ph == 0));
        chk("mix_valid", 128'(mix_valid), 128'(ph == 1));
        chk("rsp_valid", 128'(rsp_valid), 128'(ph == 2));
        if (ph == 0 && just_rst) begin
          chk("rst_rsp_state", rsp_state, 128'h0);
          chk("rst_rsp_error", 128'(rsp_error), 128'h0);
          chk("rst_mix_rs1", 128'(mix_rs1), 128'h0);
          chk("rst_mix_rs2", 128'(mix_rs2), 128'h0);
          chk("rst_mix_enc", 128'(mix_enc), 128'h0);
        end
        if (ph == 1) begin
          chk("mix_rs1", 128'(mix_rs1), 128'({16'h0000, est[k*32 +: 16]}));
          chk("mix_rs2", 128'(mix_rs2), 128'({est[k*32+16 +: 16], 16'h0000}));
          chk("mix_enc", 128'(mix_enc), 128'({31'b0, eenc}));
          if (pstall) begin
            chk("stable_rs1", 128'(mix_rs1), 128'(prs1));
            chk("stable_rs2", 128'(mix_rs2), 128'(prs2));
            chk("stable_enc", 128'(mix_enc), 128'(penc));
          end
        end
        if (ph == 2) begin
          chk("rsp_state", rsp_state, ersp);
          chk("rsp_error", 128'(rsp_error), 128'(eerr));
        end
      end
      pstall = 1'b0;
      if (!reset) begin
        mv = 1'b1; ph = 0; k = 0; nr = 0; just_rst = 1'b1;
      end else begin
        just_rst = 1'b0;
        case (ph)
          0: if (req_valid) begin
            ph = 1; k = 0; nr = 0; est = req_state; eenc = req_enc;
            ersp = mixstate(req_state, req_enc); eerr = 1'b0; n_acc++;
          end
          1: if (mix_ready) begin
            k++; nr = 0;
            if (k == 4) ph = 2;
          end else begin
            nr++;
            if (nr == MAX_WAIT) begin
              ph = 2; eerr = 1'b1; ersp = '0;
            end else begin
              pstall = 1'b1; prs1 = mix_rs1; prs2 = mix_rs2; penc = mix_enc;
            end
          end
          default: if (rsp_ready) ph = 0;
        endcase
      end
    end
  end

  task automatic run_req(input logic [127:0] st, input logic en,
                         output logic [127:0] rs, output logic er, output int lat,
                         output logic [31:0] r1, output logic [31:0] r2, output logic [31:0] e0);
    int n;
    req_state = st; req_enc = en; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    req_valid = 1'b0; req_state = ~st; req_enc = ~en;
    r1 = mix_rs1; r2 = mix_rs2; e0 = mix_enc;
    lat = 0;
    while (!rsp_valid && lat < 300) begin @(posedge clock); #1; lat++; end
    chk("rsp_arrives", 128'(rsp_valid), 128'h1);
    rs = rsp_state; er = rsp_error;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] rs, t1i, t1o, rnd;
    logic er;
    int lat, acc0;
    logic [31:0] r1, r2, e0;
    t1i = 128'hd5d4d4d4_c6c6c6c6_01010101_455313db;
    t1o = 128'hd6d7d5d5_c6c6c6c6_01010101_bca14d8e;
    reset = 1'b0; req_valid = 1'b0; req_state = '0; req_enc = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    chk("golden_enc", mixstate(t1i, 1'b1), t1o);
    chk("golden_dec", mixstate(t1o, 1'b0), t1i);
    chk("reset_req_ready", 128'(req_ready), 128'h1);
    chk("reset_rsp_state", rsp_state, 128'h0);

    // Encrypt, combinational unit
    run_req(t1i, 1'b1, rs, er, lat, r1, r2, e0);
    chk("enc_state", rs, t1o);
    chk("enc_error", 128'(er), 128'h0);
    chk("enc_latency", 128'(lat), 128'd4);
    chk("enc_col0_rs1", 128'(r1), 128'h000013db);
    chk("enc_col0_rs2", 128'(r2), 128'h45530000);
    chk("enc_col0_enc", 128'(e0), 128'h1);

    // Decrypt round trip
    run_req(t1o, 1'b0, rs, er, lat, r1, r2, e0);
    chk("dec_state", rs, t1i);
    chk("dec_error", 128'(er), 128'h0);
    chk("dec_enc", 128'(e0), 128'h0);

    // Ready delayed three cycles per column
    delay = 3;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_req(rnd, 1'b1, rs, er, lat, r1, r2, e0);
    chk("slow_state", rs, mixstate(rnd, 1'b1));
    chk("slow_latency", 128'(lat), 128'd16);
    run_req(rnd, 1'b0, rs, er, lat, r1, r2, e0);
    chk("slow_dec_state", rs, mixstate(rnd, 1'b0));

    // Unit never ready: watchdog abort, then a normal request
    delay = 0; stall_all = 1'b1;
    run_req(t1i, 1'b1, rs, er, lat, r1, r2, e0);
    chk("abort_state", rs, 128'h0);
    chk("abort_error", 128'(er), 128'h1);
    chk("abort_latency", 128'(lat), 128'd16);
    chk("abort_mix_valid", 128'(mix_valid), 128'h0);
    stall_all = 1'b0;
    run_req(t1i, 1'b1, rs, er, lat, r1, r2, e0);
    chk("post_abort_state", rs, t1o);
    chk("post_abort_error", 128'(er), 128'h0);

    // Response back-pressure with a competing request
    rsp_ready = 1'b0;
    run_req(t1i, 1'b1, rs, er, lat, r1, r2, e0);
    acc0 = n_acc;
    req_valid = 1'b1; req_state = t1o; req_enc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("bp_state", rsp_state, t1o);
      chk("bp_req_ready", 128'(req_ready), 128'h0);
    end
    req_valid = 1'b0;
    chk("bp_no_accept", 128'(n_acc), 128'(acc0));
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_release", 128'(rsp_valid), 128'h0);

    // Reset during column 2
    delay = 3;
    req_state = rnd; req_enc = 1'b1; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    chk("midrst_req_ready", 128'(req_ready), 128'h1);
    chk("midrst_mix_valid", 128'(mix_valid), 128'h0);
    chk("midrst_rsp_valid", 128'(rsp_valid), 128'h0);
    chk("midrst_rsp_state", rsp_state, 128'h0);

    delay = 0;
    run_req(t1i, 1'b1, rs, er, lat, r1, r2, e0);
    chk("recover_state", rs, t1o);
    chk("recover_latency", 128'(lat), 128'd4);
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/xc_aesmix_seq.md
# xc_aesmix_seq

Request-side sequencer for the AES MixColumns instruction unit (`xc_aesmix` interface). It accepts a full 128-bit AES state plus an encrypt/decrypt flag and issues four single-column MixColumns operations over the unit's valid/ready interface. It packs each column into the unit's rs1/rs2 layout, holds operands stable until ready, and reassembles the four results into a 128-bit response. It sits between a state-level datapath (key-schedule/round controller) and one shared `xc_aesmix` instance, and it includes a stall watchdog.

## Interface
Parameters:
- MAX_WAIT, 16: cycles tolerated per column with mix_valid high and mix_ready low before abort; legal range 1..255.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  1  upstream request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_state  in  128  AES state; column i = req_state[32i+31:32i], byte j of column = bits [8j+7:8j].
- req_enc  in  1  1 = forward MixColumns, 0 = InvMixColumns.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  downstream accepts response.
- rsp_state  out  128  transformed state, same column/byte layout as req_state.
- rsp_error  out  1  qualifies rsp_valid; 1 = watchdog abort.
- mix_valid  out  1  operand valid to mix unit.
- mix_rs1  out  32  {16'h0, b1, b0} of current column.
- mix_rs2  out  32  {b3, b2, 16'h0} of current column.
- mix_enc  out  32  {31'b0, latched req_enc}.
- mix_ready  in  1  mix unit result valid this cycle; may be high in the same cycle mix_valid rises.
- mix_result  in  32  transformed column {b3', b2', b1', b0'}.

## Operation
- States: IDLE, RUN, RESP.
- IDLE: req_ready = 1. When req_valid && req_ready, latch req_state and req_enc, clear col to 0, clear the wait counter, and go to RUN.
- RUN: mix_valid = 1. Operands come from the latched column col (2-bit).
  - On a cycle with mix_ready = 1, write mix_result into result column col and clear the wait counter.
  - If col = 3, go to RESP with rsp_error = 0. Otherwise increment col and stay in RUN; the next column's operands appear the following cycle with mix_valid still high.
  - On a cycle with mix_ready = 0, increment the wait counter. When the counter reaches MAX_WAIT, go to RESP with rsp_error = 1 and rsp_state = 0.
- RESP: rsp_valid = 1 and rsp_state/rsp_error are held stable. On rsp_ready, go to IDLE.
- Operand stability: mix_rs1, mix_rs2 and mix_enc are registered from the latched state and col. They change only on the edge that captures a mix_ready. mix_valid never drops between columns of one request.
- Outputs outside RUN: mix_valid = 0; mix_rs1/mix_rs2/mix_enc hold their last values (no requirement on those values).
- A request arriving while not IDLE is not accepted; req_ready = 0.
- req_state/req_enc changes after acceptance have no effect.
- Reset (reset = 0 at an edge), from any state including mid-RUN: state is IDLE, col = 0, wait counter = 0, all result registers = 0.
  - Outputs after reset: req_ready = 1, rsp_valid = 0, rsp_error = 0, rsp_state = 0, mix_valid = 0, mix_rs1 = 0, mix_rs2 = 0, mix_enc = 0.
  - A reset in the same cycle as a mix_ready or rsp_ready wins; nothing is captured.

## Timing
- Acceptance edge is E0. mix_valid is high from E0 to the edge that captures column 3.
- With mix_ready tied high (combinational unit): columns are captured at edges E1..E4, and rsp_valid is high from E4 until the rsp_ready edge. Minimum latency from acceptance to response is 4 cycles. Minimum throughput is one request per 6 cycles: accept, 4 RUN cycles, 1 RESP cycle with rsp_ready = 1, then IDLE.
- Each extra cycle of mix_ready low adds one cycle.
- Abort: if a column sees MAX_WAIT consecutive not-ready cycles, rsp_valid rises on the edge at which the counter reaches MAX_WAIT.
- No combinational path from any input to any output, except req_ready, which is decoded from state only.

## Test plan
- Encrypt, combinational unit, req_state = {0xd5d4d4d4, 0xc6c6c6c6, 0x01010101, 0x455313db} (col3..col0), req_enc = 1 -> rsp_state = {0xd6d7d5d5, 0xc6c6c6c6, 0x01010101, 0xbca14d8e}, rsp_error = 0, rsp_valid 4 cycles after acceptance. Column 0 operands: mix_rs1 = 0x000013db, mix_rs2 = 0x45530000, mix_enc = 1.
- Decrypt the test-1 result with req_enc = 0 -> rsp_state equals the test-1 input exactly, and mix_enc = 0 throughout.
- Unit with ready delayed 3 cycles per column, random state -> result matches the golden model, latency = 16 cycles, and mix_rs1/mix_rs2/mix_enc are stable on every mix_valid && !mix_ready cycle.
- mix_ready held 0, MAX_WAIT = 16 -> rsp_valid with rsp_error = 1 and rsp_state = 0, 16 cycles after acceptance; mix_valid = 0 in RESP; the next request completes normally.
- Back-pressure and reset:
  - Hold rsp_ready = 0 for 10 cycles -> rsp_state constant and req_ready = 0; a second req_valid is not accepted.
  - Assert reset for one cycle during RUN col 2 -> the next cycle shows req_ready = 1, mix_valid = 0, rsp_valid = 0, rsp_state = 0.
